// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register and one-entry skid buffer for the RV32I pipeline.
// Optional macro IFU_MISALIGN_TRAP_EN: misaligned redirects raise a sticky trap and halt fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_IR,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {ST_ISSUE, ST_WAIT, ST_HOLD, ST_DROP, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD, ST_DROP} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic        skid_valid;
  logic [31:0] skid_ir;
  logic [31:0] skid_pc;
  logic [31:0] redir_target;

`ifdef IFU_MISALIGN_TRAP_EN
  logic redir_misaligned;
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redir_target     = redirect_pc;
`else
  assign redir_target     = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Request strobe is live in ISSUE so the first fetch leaves in the first cycle out of reset.
  assign imem_req    = !rst && (state == ST_ISSUE) && !redirect;
  assign imem_addr   = pc;
  assign id_pc_plus4 = id_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ISSUE;
      pc         <= RESET_PC;
      skid_valid <= 1'b0;
      skid_ir    <= NOP_INSTR;
      skid_pc    <= RESET_PC;
      id_valid   <= 1'b0;
      id_IR      <= NOP_INSTR;
      id_pc      <= RESET_PC;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end
`ifdef IFU_MISALIGN_TRAP_EN
    else if (state == ST_HALT) begin
      // Terminal until reset; any late response is simply ignored.
      state <= ST_HALT;
    end else if (redirect && redir_misaligned) begin
      misalign_trap <= 1'b1;
      state         <= ST_HALT;
      skid_valid    <= 1'b0;
      id_valid      <= 1'b0;
      id_IR         <= NOP_INSTR;
    end
`endif
    else if (redirect) begin
      // Flush everything in flight; an outstanding request becomes an orphan to drop.
      pc         <= redir_target;
      skid_valid <= 1'b0;
      id_valid   <= 1'b0;
      id_IR      <= NOP_INSTR;
      case (state)
        ST_WAIT, ST_DROP: state <= imem_rvalid ? ST_ISSUE : ST_DROP;
        default:          state <= ST_ISSUE;
      endcase
    end else begin
      case (state)
        ST_ISSUE: begin
          state <= ST_WAIT;
          if (!stall) begin
            id_valid <= 1'b0;
            id_IR    <= NOP_INSTR;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            pc <= pc + 32'd4;
            if (!stall) begin
              id_valid <= 1'b1;
              id_IR    <= imem_rdata;
              id_pc    <= pc;
              state    <= ST_ISSUE;
            end else begin
              skid_valid <= 1'b1;
              skid_ir    <= imem_rdata;
              skid_pc    <= pc;
              state      <= ST_HOLD;
            end
          end else if (!stall) begin
            id_valid <= 1'b0;
            id_IR    <= NOP_INSTR;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            id_valid   <= skid_valid;
            id_IR      <= skid_valid ? skid_ir : NOP_INSTR;
            id_pc      <= skid_valid ? skid_pc : id_pc;
            skid_valid <= 1'b0;
            state      <= ST_ISSUE;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) state <= ST_ISSUE;
          if (!stall) begin
            id_valid <= 1'b0;
            id_IR    <= NOP_INSTR;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a memory model answers requests, expected
// deliveries are queued per fetch epoch, and a negedge monitor checks the IF/ID outputs.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_IR;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_IR(id_IR), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef IFU_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: memory with one outstanding request, fetch stream, epochs.
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic        out_pend = 1'b0;
  int          out_cnt = 0;
  logic [31:0] out_addr = '0;
  int          out_epoch = 0;
  int          epoch = 0;
  logic [31:0] next_fetch = RESET_PC;
  logic        halted = 1'b0;
  int          idle = 0;
  logic        last_rst = 1'b1;
  logic        last_stall = 1'b0;
  logic        last_redirect = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances as if the next posedge has happened.
  task automatic step(input logic s, input logic rd, input logic [31:0] rpc, input int lat,
                      input logic r);
    logic had_pend;
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    if (!r && out_pend && out_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = out_addr ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (r) begin
      chk("reset_req", 32'(imem_req), 32'd0);
      out_pend = 1'b0;
      exp_q.delete();
      epoch++;
      next_fetch = RESET_PC;
      halted = 1'b0;
      idle = 0;
    end else begin
      had_pend = out_pend;
      if (out_pend) begin
        if (out_cnt == 0) begin
          out_pend = 1'b0;
          if (out_epoch == epoch && !rd) exp_q.push_back('{out_addr, out_addr ^ KEY});
        end else begin
          out_cnt--;
        end
      end
      if (rd && !halted) begin
        epoch++;
        exp_q.delete();
`ifdef IFU_MISALIGN_TRAP_EN
        if (rpc[1:0] != 2'b00) halted = 1'b1;
        next_fetch = rpc;
`else
        next_fetch = {rpc[31:2], 2'b00};
`endif
      end
      if (imem_req) begin
        req_log.push_back(imem_addr);
        chk("one_outstanding", 32'(had_pend), 32'd0);
        chk("halt_no_req", 32'(halted), 32'd0);
        chk("fetch_addr", imem_addr, next_fetch);
        next_fetch = next_fetch + 32'd4;
        out_pend  = 1'b1;
        out_addr  = imem_addr;
        out_cnt   = lat - 1;
        out_epoch = epoch;
        idle = 0;
      end else if (!halted) begin
        idle++;
        if (idle == 200) begin
          checks++; errors++;
          $display("FAIL fetch_stuck: no request for 200 cycles, got 0 expected 1");
        end
      end
    end
    last_rst = r; last_stall = s; last_redirect = rd;
  endtask

  task automatic run_until_req(input logic [31:0] addr, input int lat, input bit any);
    int n;
    n = req_log.size();
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 32'd0, lat, 1'b0);
      if (req_log.size() > n && (any || req_log[req_log.size()-1] == addr)) return;
      n = req_log.size();
    end
    checks++; errors++;
    $display("FAIL req_timeout: got no request expected one to %h", addr);
  endtask

  task automatic do_reset(input int cycles);
    repeat (cycles) step(1'b0, 1'b0, 32'd0, 1, 1'b1);
    chk("reset_addr", imem_addr, RESET_PC);
    req_log.delete();
  endtask

  // Monitor: judges each IF/ID update against the scoreboard queue.
  initial begin
    logic        snap_valid;
    logic [31:0] snap_ir, snap_pc;
    exp_t        e;
    snap_valid = 1'b0; snap_ir = NOP; snap_pc = RESET_PC;
    @(negedge clk);
    forever begin
      @(negedge clk);
      chk("pc_plus4", id_pc_plus4, id_pc + 32'd4);
      if (last_rst) begin
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_ir", id_IR, NOP);
        chk("rst_pc", id_pc, RESET_PC);
      end else if (last_redirect) begin
        chk("redir_valid", 32'(id_valid), 32'd0);
        chk("redir_ir", id_IR, NOP);
      end else if (last_stall) begin
        chk("hold_valid", 32'(id_valid), 32'(snap_valid));
        chk("hold_ir", id_IR, snap_ir);
        chk("hold_pc", id_pc, snap_pc);
      end else if (id_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_delivery: got pc %h expected no instruction", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc", id_pc, e.pc);
          chk("deliver_ir", id_IR, e.ir);
        end
      end else begin
        chk("bubble_ir", id_IR, NOP);
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missed_delivery: got bubble expected pc %h", exp_q[0].pc);
        end
      end
      snap_valid = id_valid; snap_ir = id_IR; snap_pc = id_pc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] rpc;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    do_reset(3);

    // L=1 straight-line fetch: first request leaves in the first cycle out of reset.
    step(1'b0, 1'b0, 32'd0, 1, 1'b0);
    chk("first_req_count", 32'(req_log.size()), 32'd1);
    repeat (5) step(1'b0, 1'b0, 32'd0, 1, 1'b0);
    chk("seq_count", 32'(req_log.size()), 32'd3);
    if (req_log.size() >= 3) begin
      chk("seq_addr0", req_log[0], 32'h0);
      chk("seq_addr1", req_log[1], 32'h4);
      chk("seq_addr2", req_log[2], 32'h8);
    end

    // Stall across an arriving response: no request while the word sits in the skid buffer.
    run_until_req(32'd0, 1, 1'b1);
    n = req_log.size();
    repeat (3) step(1'b1, 1'b0, 32'd0, 1, 1'b0);
    chk("no_req_in_hold", 32'(req_log.size()), 32'(n));
    repeat (4) step(1'b0, 1'b0, 32'd0, 1, 1'b0);

    // L=3, redirect one cycle after the request to 0x8: the orphan must be dropped.
    do_reset(2);
    run_until_req(32'h8, 3, 1'b0);
    step(1'b0, 1'b1, 32'h100, 3, 1'b0);
    run_until_req(32'h100, 3, 1'b1);
    chk("drop_next_addr", req_log[req_log.size()-1], 32'h100);
    repeat (6) step(1'b0, 1'b0, 32'd0, 3, 1'b0);

    // Redirect and stall together while IF/ID holds a real instruction.
    for (int i = 0; i < 20 && !id_valid; i++) step(1'b0, 1'b0, 32'd0, 1, 1'b0);
    chk("have_valid_entry", 32'(id_valid), 32'd1);
    step(1'b1, 1'b1, 32'h200, 1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 32'd0, 1, 1'b0);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1, 1'b0);
    run_until_req(32'hFFFF_FFFC, 1, 1'b1);
    chk("wrap_first", req_log[req_log.size()-1], 32'hFFFF_FFFC);
    run_until_req(32'h0, 1, 1'b1);
    chk("wrap_next", req_log[req_log.size()-1], 32'h0000_0000);
    repeat (3) step(1'b0, 1'b0, 32'd0, 1, 1'b0);

    // Misaligned redirect target.
    step(1'b0, 1'b1, 32'h102, 1, 1'b0);
`ifdef IFU_MISALIGN_TRAP_EN
    n = req_log.size();
    repeat (10) step(1'b0, 1'b0, 32'd0, 1, 1'b0);
    chk("trap_set", 32'(misalign_trap), 32'd1);
    chk("halt_req_count", 32'(req_log.size()), 32'(n));
    do_reset(2);
    chk("trap_cleared", 32'(misalign_trap), 32'd0);
`else
    run_until_req(32'h100, 1, 1'b1);
    chk("misalign_addr", req_log[req_log.size()-1], 32'h100);
`endif

    // Randomized traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rpc,
           int'($urandom_range(1, 4)), $urandom_range(0, 499) == 0);
    end
    repeat (10) step(1'b0, 1'b0, 32'd0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
